// File: rtl/seq_pkg.sv
// Shared opcode, state, fault and status definitions for the pulse-sequencer engine.
package seq_pkg;

  typedef enum logic [3:0] {
    OP_CONT       = 4'd0,
    OP_STOP       = 4'd1,
    OP_LOOP       = 4'd2,
    OP_END_LOOP   = 4'd3,
    OP_JSR        = 4'd4,
    OP_RTS        = 4'd5,
    OP_BRANCH     = 4'd6,
    OP_LONG_DELAY = 4'd7,
    OP_WAIT       = 4'd8
  } opcode_t;

  typedef enum logic [1:0] {
    FLT_NONE      = 2'd0,
    FLT_OVERFLOW  = 2'd1,
    FLT_UNDERFLOW = 2'd2,
    FLT_ILLEGAL   = 2'd3
  } fault_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DISPATCH,
    S_DWELL,
    S_WAIT,
    S_FAULT
  } state_t;

  localparam logic [3:0] ST_RESET = 4'h2;
  localparam logic [3:0] ST_IDLE  = 4'h1;
  localparam logic [3:0] ST_RUN   = 4'h4;
  localparam logic [3:0] ST_WAIT  = 4'h8;
  localparam logic [3:0] ST_FAULT = 4'hF;

  function automatic logic [3:0] status_of(input state_t s);
    case (s)
      S_IDLE:              return ST_IDLE;
      S_DISPATCH, S_DWELL: return ST_RUN;
      S_WAIT:              return ST_WAIT;
      default:             return ST_FAULT;
    endcase
  endfunction

endpackage

// File: rtl/seq_stack.sv
// Synchronous LIFO used for the loop and call stacks; push/pop/wr_top are mutually exclusive.
module seq_stack #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic             wr_top,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    cnt_q;
  logic [IW-1:0]    wr_idx;
  logic [IW-1:0]    top_idx;

  assign wr_idx  = IW'(cnt_q);
  assign top_idx = IW'(cnt_q - CW'(1));
  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign top     = mem_q[top_idx];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (push && !full) begin
      mem_q[wr_idx] <= din;
      cnt_q         <= cnt_q + CW'(1);
    end else if (pop && !empty) begin
      cnt_q <= cnt_q - CW'(1);
    end else if (wr_top && !empty) begin
      mem_q[top_idx] <= din;
    end
  end

endmodule

// File: rtl/sequencer_core.sv
// Pulse-sequencer instruction engine: fetch/dispatch, dwell timing, nested loops and calls, fault trap.
module sequencer_core
  import seq_pkg::*;
#(
  parameter int unsigned    N_CH       = 64,
  parameter int unsigned    ADDR_W     = 16,
  parameter int unsigned    DATA_W     = 20,
  parameter int unsigned    TIME_W     = 32,
  parameter int unsigned    LOOP_DEPTH = 4,
  parameter int unsigned    CALL_DEPTH = 4,
  parameter logic [N_CH-1:0] SAFE_CH   = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              trigger,
  input  logic [N_CH-1:0]   flg,
  input  logic [3:0]        op_code,
  input  logic [DATA_W-1:0] data,
  input  logic [TIME_W-1:0] time_arg,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [N_CH-1:0]   channels,
  output logic [3:0]        status,
  output logic [1:0]        fault_code,
  output logic              start_monitor
);

  localparam int unsigned DW = DATA_W + TIME_W;
  localparam int unsigned LW = ADDR_W + DATA_W;

  state_t              state_q, state_d, after_q, after_d, after_c;
  fault_t              fault_q, fault_d, fault_c;
  logic [ADDR_W-1:0]   addr_q, addr_d, addr_inc, nxt_c;
  logic [N_CH-1:0]     ch_q, ch_d;
  logic [DW-1:0]       dwell_q, dwell_d, dw_c;
  logic [3:0]          status_q, status_d;
  logic                start_q, start_d;
  logic                run_q, trig_q, run_rise, dispatch, stk_clear;

  logic                lp_push, lp_pop, lp_wr, lp_full, lp_empty;
  logic [LW-1:0]       lp_din, lp_top;
  logic [ADDR_W-1:0]   lp_start;
  logic [DATA_W-1:0]   lp_rem;
  logic                cs_push, cs_pop, cs_full, cs_empty;
  logic [ADDR_W-1:0]   cs_top;

  assign addr_inc = addr_q + ADDR_W'(1);
  assign lp_start = lp_top[LW-1:DATA_W];
  assign lp_rem   = lp_top[DATA_W-1:0];
  assign run_rise = run && !run_q;
  // A WAIT that sees the registered trigger dispatches in that same cycle.
  assign dispatch = (state_q == S_DISPATCH) || ((state_q == S_WAIT) && trig_q);

  always_comb begin
    state_d   = state_q;
    after_d   = after_q;
    fault_d   = fault_q;
    addr_d    = addr_q;
    ch_d      = ch_q;
    dwell_d   = dwell_q;
    start_d   = 1'b0;
    stk_clear = 1'b0;
    lp_push   = 1'b0;
    lp_pop    = 1'b0;
    lp_wr     = 1'b0;
    lp_din    = '0;
    cs_push   = 1'b0;
    cs_pop    = 1'b0;
    fault_c   = FLT_NONE;
    nxt_c     = addr_inc;
    after_c   = S_DISPATCH;
    dw_c      = DW'(time_arg);

    case (state_q)
      S_IDLE: if (run_rise) begin
        state_d   = S_DISPATCH;
        start_d   = 1'b1;
        stk_clear = 1'b1;
      end
      S_DWELL: if (dwell_q <= DW'(1)) state_d = after_q;
               else dwell_d = dwell_q - DW'(1);
      default: ;
    endcase

    if (dispatch) begin
      case (op_code)
        OP_CONT: ;
        OP_STOP: begin
          nxt_c   = '0;
          after_c = S_IDLE;
        end
        OP_LOOP: if (lp_full) fault_c = FLT_OVERFLOW;
                 else begin
                   lp_push = 1'b1;
                   lp_din  = {addr_inc, (data == '0) ? DATA_W'(1) : data};
                 end
        OP_END_LOOP: if (lp_empty) fault_c = FLT_UNDERFLOW;
                     else if (lp_rem > DATA_W'(1)) begin
                       lp_wr  = 1'b1;
                       lp_din = {lp_start, lp_rem - DATA_W'(1)};
                       nxt_c  = lp_start;
                     end else lp_pop = 1'b1;
        OP_JSR: begin
          if (cs_full) fault_c = FLT_OVERFLOW;
          else cs_push = 1'b1;
          nxt_c = ADDR_W'(data);
        end
        OP_RTS: begin
          if (cs_empty) fault_c = FLT_UNDERFLOW;
          else cs_pop = 1'b1;
          nxt_c = cs_top;
        end
        OP_BRANCH:     nxt_c = ADDR_W'(data);
        OP_LONG_DELAY: dw_c = DW'(data) * DW'(time_arg);
        OP_WAIT:       after_c = S_WAIT;
        default:       fault_c = FLT_ILLEGAL;
      endcase

      if (fault_c != FLT_NONE) begin
        state_d = S_FAULT;
        fault_d = fault_c;
        ch_d    = SAFE_CH;
      end else begin
        ch_d    = flg;
        addr_d  = nxt_c;
        dwell_d = dw_c;
        if (dw_c == '0) state_d = after_c;
        else begin
          state_d = S_DWELL;
          after_d = after_c;
        end
      end
    end

    status_d = status_of(state_d);
  end

  always_ff @(posedge clk) begin
    run_q  <= run;
    trig_q <= trigger;
    if (reset) begin
      state_q  <= S_IDLE;
      after_q  <= S_DISPATCH;
      fault_q  <= FLT_NONE;
      addr_q   <= '0;
      ch_q     <= '0;
      dwell_q  <= '0;
      status_q <= ST_RESET;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      after_q  <= after_d;
      fault_q  <= fault_d;
      addr_q   <= addr_d;
      ch_q     <= ch_d;
      dwell_q  <= dwell_d;
      status_q <= status_d;
      start_q  <= start_d;
    end
  end

  seq_stack #(.WIDTH(LW), .DEPTH(LOOP_DEPTH)) u_loop_stack (
    .clk(clk), .reset(reset), .clear(stk_clear),
    .push(lp_push), .pop(lp_pop), .wr_top(lp_wr), .din(lp_din),
    .top(lp_top), .full(lp_full), .empty(lp_empty)
  );

  seq_stack #(.WIDTH(ADDR_W), .DEPTH(CALL_DEPTH)) u_call_stack (
    .clk(clk), .reset(reset), .clear(stk_clear),
    .push(cs_push), .pop(cs_pop), .wr_top(1'b0), .din(addr_inc),
    .top(cs_top), .full(cs_full), .empty(cs_empty)
  );

  assign mem_addr      = addr_q;
  assign channels      = ch_q;
  assign status        = status_q;
  assign fault_code    = fault_q;
  assign start_monitor = start_q;

endmodule

// File: tb/tb_sequencer_core.sv
// Directed bench for sequencer_core: per-cycle vector table plus multi-cycle sequences.
module tb_sequencer_core;
  import seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset, run, trigger;
  logic [63:0] flg;
  logic [3:0]  op_code;
  logic [19:0] data;
  logic [31:0] time_arg;
  logic [15:0] mem_addr;
  logic [63:0] channels;
  logic [3:0]  status;
  logic [1:0]  fault_code;
  logic        start_monitor;

  logic [3:0]  p_op   [256];
  logic [19:0] p_data [256];
  logic [31:0] p_time [256];
  logic [63:0] p_flg  [256];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  always_comb begin
    op_code  = p_op[mem_addr[7:0]];
    data     = p_data[mem_addr[7:0]];
    time_arg = p_time[mem_addr[7:0]];
    flg      = p_flg[mem_addr[7:0]];
  end

  sequencer_core #(
    .N_CH(64), .ADDR_W(16), .DATA_W(20), .TIME_W(32),
    .LOOP_DEPTH(4), .CALL_DEPTH(4), .SAFE_CH(64'h0)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .trigger(trigger),
    .flg(flg), .op_code(op_code), .data(data), .time_arg(time_arg),
    .mem_addr(mem_addr), .channels(channels), .status(status),
    .fault_code(fault_code), .start_monitor(start_monitor)
  );

  typedef struct {
    logic        rst;
    logic        run;
    logic [63:0] ch;
    logic [15:0] addr;
    logic [3:0]  st;
    logic [1:0]  fc;
    logic        sm;
  } vec_t;

  vec_t tbl [12];

  localparam logic [63:0] CH_A = 64'hAAAA_0000_0000_0001;
  localparam logic [63:0] CH_B = 64'h0000_BBBB_0000_0002;
  localparam logic [63:0] CH_C = 64'h0000_0000_CCCC_0003;
  localparam logic [63:0] CH_P = 64'h5A5A_5A5A_5A5A_5A5A;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) begin
      p_op[i] = OP_STOP; p_data[i] = '0; p_time[i] = '0; p_flg[i] = '0;
    end
  endtask

  task automatic set_ins(input int a, input logic [3:0] op, input logic [19:0] d,
                         input logic [31:0] t, input logic [63:0] f);
    p_op[a] = op; p_data[a] = d; p_time[a] = t; p_flg[a] = f;
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; trigger = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic start();
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  task automatic run_fault(input string name, input logic [1:0] exp_fc, input logic [15:0] exp_addr);
    start();
    for (int i = 0; i < 30 && status != 4'hF; i++) tick();
    check({name, " status"}, 64'(status), 64'hF);
    check({name, " fault"}, 64'(fault_code), 64'(exp_fc));
    check({name, " safe ch"}, channels, 64'h0);
    check({name, " addr"}, 64'(mem_addr), 64'(exp_addr));
    run = 1'b0; tick(); run = 1'b1; tick(); run = 1'b0; tick();
    check({name, " run ignored"}, 64'(status), 64'hF);
    check({name, " addr held"}, 64'(mem_addr), 64'(exp_addr));
    do_reset();
  endtask

  initial begin
    int exp2 [8];
    int exp3 [6];
    int cnt, body;

    reset = 1'b1; run = 1'b0; trigger = 1'b0;

    // Basic dwell timing from reset: A held 4 cycles, B 1 cycle, then idle at 0.
    clear_prog();
    set_ins(0, OP_CONT, 20'd0, 32'd3, CH_A);
    set_ins(1, OP_CONT, 20'd0, 32'd0, CH_B);
    set_ins(2, OP_STOP, 20'd0, 32'd0, CH_C);
    tbl[0]  = '{1'b1, 1'b0, 64'h0, 16'd0, 4'h2, 2'd0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 64'h0, 16'd0, 4'h2, 2'd0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 64'h0, 16'd0, 4'h1, 2'd0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 64'h0, 16'd0, 4'h4, 2'd0, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, CH_A,  16'd1, 4'h4, 2'd0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, CH_A,  16'd1, 4'h4, 2'd0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, CH_A,  16'd1, 4'h4, 2'd0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, CH_A,  16'd1, 4'h4, 2'd0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, CH_B,  16'd2, 4'h4, 2'd0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, CH_C,  16'd0, 4'h1, 2'd0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, CH_C,  16'd0, 4'h1, 2'd0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, CH_C,  16'd0, 4'h1, 2'd0, 1'b0};
    for (int i = 0; i < 12; i++) begin
      reset = tbl[i].rst;
      run   = tbl[i].run;
      tick();
      check($sformatf("vec%0d channels", i), channels, tbl[i].ch);
      check($sformatf("vec%0d mem_addr", i), 64'(mem_addr), 64'(tbl[i].addr));
      check($sformatf("vec%0d status", i), 64'(status), 64'(tbl[i].st));
      check($sformatf("vec%0d fault", i), 64'(fault_code), 64'(tbl[i].fc));
      check($sformatf("vec%0d start_mon", i), 64'(start_monitor), 64'(tbl[i].sm));
    end

    // Single loop of 3.
    do_reset();
    clear_prog();
    set_ins(0, OP_LOOP, 20'd3, 32'd0, CH_A);
    set_ins(1, OP_CONT, 20'd0, 32'd0, CH_B);
    set_ins(2, OP_END_LOOP, 20'd0, 32'd0, CH_C);
    set_ins(3, OP_STOP, 20'd0, 32'd0, CH_A);
    exp2 = '{0, 1, 2, 1, 2, 1, 2, 3};
    start();
    for (int i = 0; i < 8; i++) begin
      check($sformatf("loop addr%0d", i), 64'(mem_addr), 64'(exp2[i]));
      tick();
    end
    check("loop done status", 64'(status), 64'h1);

    // Nested loops 2 x 3.
    do_reset();
    clear_prog();
    set_ins(0, OP_LOOP, 20'd2, 32'd0, CH_A);
    set_ins(1, OP_LOOP, 20'd3, 32'd0, CH_A);
    set_ins(2, OP_CONT, 20'd0, 32'd0, CH_B);
    set_ins(3, OP_END_LOOP, 20'd0, 32'd0, CH_A);
    set_ins(4, OP_END_LOOP, 20'd0, 32'd0, CH_A);
    set_ins(5, OP_STOP, 20'd0, 32'd0, CH_C);
    start();
    cnt = 0; body = 0;
    for (int i = 0; i < 100 && status != 4'h1; i++) begin
      if (mem_addr == 16'd2) body++;
      cnt++;
      tick();
    end
    check("nest done status", 64'(status), 64'h1);
    check("nest body count", 64'(body), 64'd6);
    check("nest dispatch count", 64'(cnt), 64'd18);

    // Nested subroutine call and return.
    do_reset();
    clear_prog();
    set_ins(0,  OP_JSR,  20'd10, 32'd0, CH_A);
    set_ins(1,  OP_STOP, 20'd0,  32'd0, CH_C);
    set_ins(10, OP_JSR,  20'd20, 32'd0, CH_A);
    set_ins(11, OP_RTS,  20'd0,  32'd0, CH_A);
    set_ins(20, OP_CONT, 20'd0,  32'd0, CH_B);
    set_ins(21, OP_RTS,  20'd0,  32'd0, CH_A);
    exp3 = '{0, 10, 20, 21, 11, 1};
    start();
    for (int i = 0; i < 6; i++) begin
      check($sformatf("jsr addr%0d", i), 64'(mem_addr), 64'(exp3[i]));
      tick();
    end
    check("jsr done status", 64'(status), 64'h1);
    check("jsr done channels", channels, CH_C);

    // LONG_DELAY 4 x 3 -> held 13 cycles.
    do_reset();
    clear_prog();
    set_ins(0, OP_LONG_DELAY, 20'd4, 32'd3, CH_A);
    set_ins(1, OP_CONT, 20'd0, 32'd0, CH_B);
    set_ins(2, OP_STOP, 20'd0, 32'd0, CH_C);
    start();
    tick();
    cnt = 0;
    for (int i = 0; i < 100 && channels == CH_A; i++) begin
      cnt++;
      tick();
    end
    check("long hold cycles", 64'(cnt), 64'd13);
    check("long next channels", channels, CH_B);

    // LONG_DELAY product 2^32 must not truncate; then reset mid-dwell.
    do_reset();
    clear_prog();
    set_ins(0, OP_LONG_DELAY, 20'd2, 32'h8000_0000, CH_A);
    set_ins(1, OP_CONT, 20'd0, 32'd0, CH_B);
    start();
    tick();
    repeat (60) tick();
    check("wide hold channels", channels, CH_A);
    check("wide hold status", 64'(status), 64'h4);
    check("wide hold addr", 64'(mem_addr), 64'd1);
    reset = 1'b1;
    tick();
    check("mid reset channels", channels, 64'h0);
    check("mid reset addr", 64'(mem_addr), 64'd0);
    check("mid reset status", 64'(status), 64'h2);
    check("mid reset fault", 64'(fault_code), 64'd0);
    check("mid reset start_mon", 64'(start_monitor), 64'd0);
    reset = 1'b0;
    tick();
    check("post reset status", 64'(status), 64'h1);

    // WAIT with T=5: early trigger ignored, later trigger dispatches.
    do_reset();
    clear_prog();
    set_ins(0, OP_WAIT, 20'd0, 32'd5, CH_A);
    set_ins(1, OP_CONT, 20'd0, 32'd0, CH_B);
    set_ins(2, OP_STOP, 20'd0, 32'd0, CH_C);
    start();
    tick();
    check("wait k0 channels", channels, CH_A);
    for (int k = 1; k <= 12; k++) begin
      trigger = (k == 2 || k == 10);
      tick();
      if (k <= 4) begin
        check($sformatf("wait k%0d status", k), 64'(status), 64'h4);
        check($sformatf("wait k%0d channels", k), channels, CH_A);
      end else if (k <= 10) begin
        check($sformatf("wait k%0d status", k), 64'(status), 64'h8);
        check($sformatf("wait k%0d channels", k), channels, CH_A);
      end else if (k == 11) begin
        check("wait k11 status", 64'(status), 64'h4);
        check("wait k11 channels", channels, CH_B);
      end else begin
        check("wait k12 status", 64'(status), 64'h1);
        check("wait k12 channels", channels, CH_C);
      end
    end
    trigger = 1'b0;

    // Faults: call overflow, loop underflow, return underflow, illegal opcode.
    do_reset();
    clear_prog();
    set_ins(0,  OP_JSR, 20'd30, 32'd0, CH_P);
    set_ins(30, OP_JSR, 20'd31, 32'd0, CH_P);
    set_ins(31, OP_JSR, 20'd32, 32'd0, CH_P);
    set_ins(32, OP_JSR, 20'd33, 32'd0, CH_P);
    set_ins(33, OP_JSR, 20'd34, 32'd0, CH_P);
    run_fault("ovf", 2'd1, 16'd33);

    clear_prog();
    set_ins(0, OP_END_LOOP, 20'd0, 32'd0, CH_P);
    run_fault("loop udf", 2'd2, 16'd0);

    clear_prog();
    set_ins(0, OP_CONT, 20'd0, 32'd0, CH_P);
    set_ins(1, OP_RTS, 20'd0, 32'd0, CH_P);
    run_fault("rts udf", 2'd2, 16'd1);

    clear_prog();
    set_ins(0, OP_CONT, 20'd0, 32'd0, CH_P);
    set_ins(1, 4'hC, 20'd0, 32'd0, CH_P);
    run_fault("illegal", 2'd3, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
